// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS-subset processor: ALU, decoder, datapath, register file,
// instruction ROM and data RAM. One instruction commits per rising clock edge.

package mips_core_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] IMM_SIGN = 2'd0;
  localparam logic [1:0] IMM_ZERO = 2'd1;
  localparam logic [1:0] IMM_LUI  = 2'd2;
endpackage

module mips_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alucontrol,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = 32'h0;
    case (alucontrol)
      3'b000: result = a & b;
      3'b001: result = a | b;
      3'b010: result = a + b;
      3'b011: result = b;
      3'b100: result = a & ~b;
      3'b101: result = a | ~b;
      3'b110: result = a - b;
      3'b111: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);
endmodule

module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] registers [0:31];

  // Entry 0 is never written, so it holds its reset value of zero forever.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) registers[i] <= 32'h0;
    end else if (we_i && (wa_i != 5'd0)) begin
      registers[wa_i] <= wd_i;
    end
  end

  assign rd1_o = registers[ra1_i];
  assign rd2_o = registers[ra2_i];
endmodule

module mips_decoder
  import mips_core_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       alusrc_o,
  output logic       memwrite_o,
  output logic       memtoreg_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic [1:0] immsel_o,
  output logic [2:0] alucontrol_o
);
  // Anything not matched below leaves every control low: a nop.
  always_comb begin
    regwrite_o   = 1'b0;
    regdst_o     = 1'b0;
    alusrc_o     = 1'b0;
    memwrite_o   = 1'b0;
    memtoreg_o   = 1'b0;
    branch_o     = 1'b0;
    jump_o       = 1'b0;
    immsel_o     = IMM_SIGN;
    alucontrol_o = 3'b010;
    case (op_i)
      OP_RTYPE: begin
        regdst_o = 1'b1;
        case (funct_i)
          FN_ADD: begin regwrite_o = 1'b1; alucontrol_o = 3'b010; end
          FN_SUB: begin regwrite_o = 1'b1; alucontrol_o = 3'b110; end
          FN_AND: begin regwrite_o = 1'b1; alucontrol_o = 3'b000; end
          FN_OR:  begin regwrite_o = 1'b1; alucontrol_o = 3'b001; end
          FN_SLT: begin regwrite_o = 1'b1; alucontrol_o = 3'b111; end
          default: regwrite_o = 1'b0;
        endcase
      end
      OP_ADDI: begin regwrite_o = 1'b1; alusrc_o = 1'b1; end
      OP_ORI: begin
        regwrite_o   = 1'b1;
        alusrc_o     = 1'b1;
        immsel_o     = IMM_ZERO;
        alucontrol_o = 3'b001;
      end
      OP_LUI: begin
        regwrite_o   = 1'b1;
        alusrc_o     = 1'b1;
        immsel_o     = IMM_LUI;
        alucontrol_o = 3'b011;
      end
      OP_LW: begin regwrite_o = 1'b1; alusrc_o = 1'b1; memtoreg_o = 1'b1; end
      OP_SW: begin memwrite_o = 1'b1; alusrc_o = 1'b1; end
      OP_BEQ: begin branch_o = 1'b1; alucontrol_o = 3'b110; end
      OP_J: jump_o = 1'b1;
      default: jump_o = 1'b0;
    endcase
  end
endmodule

module mips_datapath
  import mips_core_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [25:0] instr_i,
  input  logic [31:0] readdata_i,
  input  logic        regwrite_i,
  input  logic        regdst_i,
  input  logic        alusrc_i,
  input  logic        memtoreg_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [1:0]  immsel_i,
  input  logic [2:0]  alucontrol_i,
  output logic [31:0] pc_o,
  output logic [31:0] aluout_o,
  output logic [31:0] writedata_o
);
  logic [31:0] pc_q, pc_d, pc_plus4, pc_branch, imm_ext;
  logic [31:0] srca, rd2, srcb, alu_result, wd3;
  logic [4:0]  wa;
  logic        alu_zero;

  always_comb begin
    imm_ext = {{16{instr_i[15]}}, instr_i[15:0]};
    if (immsel_i == IMM_ZERO)     imm_ext = {16'h0, instr_i[15:0]};
    else if (immsel_i == IMM_LUI) imm_ext = {instr_i[15:0], 16'h0};
  end

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_branch = pc_plus4 + {imm_ext[29:0], 2'b00};

  always_comb begin
    pc_d = pc_plus4;
    if (jump_i)                    pc_d = {pc_plus4[31:28], instr_i[25:0], 2'b00};
    else if (branch_i && alu_zero) pc_d = pc_branch;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pc_q <= 32'h0;
    else          pc_q <= pc_d;
  end

  assign wa   = regdst_i ? instr_i[15:11] : instr_i[20:16];
  assign wd3  = memtoreg_i ? readdata_i : alu_result;
  assign srcb = alusrc_i ? imm_ext : rd2;

  mips_regfile gpr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .ra1_i   (instr_i[25:21]),
    .ra2_i   (instr_i[20:16]),
    .we_i    (regwrite_i),
    .wa_i    (wa),
    .wd_i    (wd3),
    .rd1_o   (srca),
    .rd2_o   (rd2)
  );

  mips_alu alu (
    .a          (srca),
    .b          (srcb),
    .alucontrol (alucontrol_i),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  assign pc_o        = pc_q;
  assign aluout_o    = alu_result;
  assign writedata_o = rd2;
endmodule

module mips_cpu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] readdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] aluout_o,
  output logic [31:0] writedata_o,
  output logic        memwrite_o
);
  logic       regwrite, regdst, alusrc, memtoreg, branch, jump;
  logic [1:0] immsel;
  logic [2:0] alucontrol;

  mips_decoder decoder (
    .op_i         (instr_i[31:26]),
    .funct_i      (instr_i[5:0]),
    .regwrite_o   (regwrite),
    .regdst_o     (regdst),
    .alusrc_o     (alusrc),
    .memwrite_o   (memwrite_o),
    .memtoreg_o   (memtoreg),
    .branch_o     (branch),
    .jump_o       (jump),
    .immsel_o     (immsel),
    .alucontrol_o (alucontrol)
  );

  mips_datapath dp (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .instr_i      (instr_i[25:0]),
    .readdata_i   (readdata_i),
    .regwrite_i   (regwrite),
    .regdst_i     (regdst),
    .alusrc_i     (alusrc),
    .memtoreg_i   (memtoreg),
    .branch_i     (branch),
    .jump_i       (jump),
    .immsel_i     (immsel),
    .alucontrol_i (alucontrol),
    .pc_o         (pc_o),
    .aluout_o     (aluout_o),
    .writedata_o  (writedata_o)
  );
endmodule

module mips_imem (
  input  logic [5:0]  addr_i,
  output logic [31:0] instr_o
);
  // Elaboration-time image; all-zero words decode as nops.
  logic [31:0] INSTRROM [0:63] = '{default: 32'h0000_0000};

  assign instr_o = INSTRROM[addr_i];
endmodule

module mips_dmem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [5:0]  addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);
  logic [31:0] DATARAM [0:63];

  always_ff @(posedge clk_i) begin
    if (we_i) DATARAM[addr_i] <= wd_i;
  end

  assign rd_o = DATARAM[addr_i];
endmodule

module mips_single_cycle_core (
  input logic clk,
  input logic reset
);
  logic [31:0] pc, instr, readdata, writedata, dataaddr;
  logic        memwrite, datawrite;
  logic        unused_bits;

  mips_cpu mips (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .instr_i     (instr),
    .readdata_i  (readdata),
    .pc_o        (pc),
    .aluout_o    (dataaddr),
    .writedata_o (writedata),
    .memwrite_o  (memwrite)
  );

  // Holding reset low blocks stores, so an aborted sw never reaches RAM.
  assign datawrite = memwrite & reset;

  mips_imem imem (
    .addr_i  (pc[7:2]),
    .instr_o (instr)
  );

  mips_dmem dmem (
    .clk_i  (clk),
    .we_i   (datawrite),
    .addr_i (dataaddr[7:2]),
    .wd_i   (writedata),
    .rd_o   (readdata)
  );

  assign unused_bits = ^{pc[31:8], pc[1:0], dataaddr[31:8], dataaddr[1:0]};
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Directed bench for mips_single_cycle_core and the standalone mips_alu.

module tb_mips_single_cycle_core;
  logic        clk;
  logic        reset;
  logic [31:0] a, b, result;
  logic [2:0]  alucontrol;
  logic        zero;
  logic [31:0] prog [0:63];
  int          total = 0;
  int          bad   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_single_cycle_core proc (
    .clk   (clk),
    .reset (reset)
  );

  mips_alu alu_dut (
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .result     (result),
    .zero       (zero)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  // Reset the core, load prog into the ROM, release reset on a falling edge.
  task automatic start_prog();
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) proc.imem.INSTRROM[i] = prog[i];
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int nonzero_regs();
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (proc.mips.dp.gpr.registers[i] !== 32'h0) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (proc.pc !== 32'h0) begin
      bad++; $display("FAIL reset_pc got=%h exp=%h", proc.pc, 32'h0);
    end
    total++;
    if (proc.datawrite !== 1'b0) begin
      bad++; $display("FAIL reset_datawrite got=%b exp=0", proc.datawrite);
    end
    total++;
    if (nonzero_regs() !== 0) begin
      bad++; $display("FAIL reset_regs nonzero=%0d exp=0", nonzero_regs());
    end
  endtask

  task automatic test_alu();
    logic [31:0] va [0:11];
    logic [31:0] vb [0:11];
    logic [2:0]  vc [0:11];
    logic [31:0] vr [0:11];
    logic        vz [0:11];
    va = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'd5, 32'd5, 32'd5, 32'd1, 32'h8000_0000};
    vb = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd1, 32'd1,
           32'd3, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    vc = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b110, 3'b111, 3'b010,
           3'b011, 3'b100, 3'b101, 3'b111, 3'b110};
    vr = '{32'd8, 32'd2, 32'd1, 32'd7, 32'd0, 32'd1, 32'd0,
           32'd3, 32'd4, 32'hFFFF_FFFD, 32'd0, 32'd1};
    vz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      a = va[i];
      b = vb[i];
      alucontrol = vc[i];
      #1;
      total++;
      if (result !== vr[i] || zero !== vz[i]) begin
        bad++;
        $display("FAIL alu_vec%0d got=%h/%b exp=%h/%b", i, result, zero, vr[i], vz[i]);
      end
    end
  endtask

  task automatic test_arith();
    clear_prog();
    prog[0] = 32'h2002_0005;  // addi $2,$0,5
    prog[1] = 32'h2003_000C;  // addi $3,$0,12
    prog[2] = 32'h0043_2020;  // add  $4,$2,$3
    prog[3] = 32'h0062_2822;  // sub  $5,$3,$2
    start_prog();
    step(4);
    total++;
    if (proc.mips.dp.gpr.registers[4] !== 32'd17) begin
      bad++; $display("FAIL arith_r4 got=%h exp=%h", proc.mips.dp.gpr.registers[4], 32'd17);
    end
    total++;
    if (proc.mips.dp.gpr.registers[5] !== 32'd7) begin
      bad++; $display("FAIL arith_r5 got=%h exp=%h", proc.mips.dp.gpr.registers[5], 32'd7);
    end
    total++;
    if (proc.pc !== 32'h10) begin
      bad++; $display("FAIL arith_pc got=%h exp=%h", proc.pc, 32'h10);
    end
  endtask

  task automatic test_memory();
    clear_prog();
    prog[0] = 32'h2004_0011;  // addi $4,$0,17
    prog[1] = 32'hAC04_0004;  // sw   $4,4($0)
    prog[2] = 32'h8C06_0004;  // lw   $6,4($0)
    start_prog();
    total++;
    if (proc.datawrite !== 1'b0) begin
      bad++; $display("FAIL mem_dw_addi got=%b exp=0", proc.datawrite);
    end
    step(1);
    total++;
    if (proc.datawrite !== 1'b1) begin
      bad++; $display("FAIL mem_dw_sw got=%b exp=1", proc.datawrite);
    end
    step(1);
    total++;
    if (proc.datawrite !== 1'b0) begin
      bad++; $display("FAIL mem_dw_lw got=%b exp=0", proc.datawrite);
    end
    total++;
    if (proc.dmem.DATARAM[1] !== 32'd17) begin
      bad++; $display("FAIL mem_ram1 got=%h exp=%h", proc.dmem.DATARAM[1], 32'd17);
    end
    step(1);
    total++;
    if (proc.mips.dp.gpr.registers[6] !== 32'd17) begin
      bad++; $display("FAIL mem_r6 got=%h exp=%h", proc.mips.dp.gpr.registers[6], 32'd17);
    end
  endtask

  task automatic test_branch_jump();
    clear_prog();
    prog[0]  = 32'h1000_0002;  // beq $0,$0,+2   -> 0x0C
    prog[3]  = 32'h2002_0001;  // addi $2,$0,1
    prog[4]  = 32'h1040_0003;  // beq $2,$0,+3   not taken
    prog[5]  = 32'h0800_0010;  // j 0x10         -> 0x40
    prog[16] = 32'h1000_FFFF;  // beq $0,$0,-1   spins at 0x40
    start_prog();
    step(1);
    total++;
    if (proc.pc !== 32'hC) begin
      bad++; $display("FAIL beq_taken_pc got=%h exp=%h", proc.pc, 32'hC);
    end
    step(1);
    total++;
    if (proc.mips.dp.gpr.registers[2] !== 32'd1) begin
      bad++; $display("FAIL bj_r2 got=%h exp=%h", proc.mips.dp.gpr.registers[2], 32'd1);
    end
    step(1);
    total++;
    if (proc.pc !== 32'h14) begin
      bad++; $display("FAIL beq_not_taken_pc got=%h exp=%h", proc.pc, 32'h14);
    end
    step(1);
    total++;
    if (proc.pc !== 32'h40) begin
      bad++; $display("FAIL jump_pc got=%h exp=%h", proc.pc, 32'h40);
    end
    step(2);
    total++;
    if (proc.pc !== 32'h40) begin
      bad++; $display("FAIL beq_back_pc got=%h exp=%h", proc.pc, 32'h40);
    end
  endtask

  task automatic test_logic_ops();
    clear_prog();
    prog[0] = 32'h3C08_1234;  // lui  $8,0x1234
    prog[1] = 32'h3508_8765;  // ori  $8,$8,0x8765
    prog[2] = 32'h2009_FFFF;  // addi $9,$0,-1
    prog[3] = 32'h0120_502A;  // slt  $10,$9,$0
    prog[4] = 32'h0109_5824;  // and  $11,$8,$9
    prog[5] = 32'hFC0D_0000;  // unknown opcode
    prog[6] = 32'h0109_6021;  // unknown funct (addu $12)
    start_prog();
    step(7);
    total++;
    if (proc.mips.dp.gpr.registers[8] !== 32'h1234_8765) begin
      bad++; $display("FAIL lui_ori_r8 got=%h exp=%h", proc.mips.dp.gpr.registers[8], 32'h1234_8765);
    end
    total++;
    if (proc.mips.dp.gpr.registers[9] !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL addi_neg_r9 got=%h exp=%h", proc.mips.dp.gpr.registers[9], 32'hFFFF_FFFF);
    end
    total++;
    if (proc.mips.dp.gpr.registers[10] !== 32'd1) begin
      bad++; $display("FAIL slt_r10 got=%h exp=%h", proc.mips.dp.gpr.registers[10], 32'd1);
    end
    total++;
    if (proc.mips.dp.gpr.registers[11] !== 32'h1234_8765) begin
      bad++; $display("FAIL and_r11 got=%h exp=%h", proc.mips.dp.gpr.registers[11], 32'h1234_8765);
    end
    total++;
    if (proc.mips.dp.gpr.registers[12] !== 32'h0 || proc.mips.dp.gpr.registers[13] !== 32'h0) begin
      bad++;
      $display("FAIL unknown_nop got=%h/%h exp=0/0",
               proc.mips.dp.gpr.registers[12], proc.mips.dp.gpr.registers[13]);
    end
    total++;
    if (proc.pc !== 32'h1C) begin
      bad++; $display("FAIL logic_pc got=%h exp=%h", proc.pc, 32'h1C);
    end
  endtask

  task automatic test_reg_zero();
    clear_prog();
    prog[0] = 32'h2000_0009;  // addi $0,$0,9
    prog[1] = 32'h2007_0003;  // addi $7,$0,3
    prog[2] = 32'h0000_3820;  // add  $7,$0,$0
    prog[3] = 32'h0800_0040;  // j 0x40 -> pc 0x100, ROM index wraps to 0
    start_prog();
    step(1);
    total++;
    if (proc.mips.dp.gpr.registers[0] !== 32'h0) begin
      bad++; $display("FAIL r0_write got=%h exp=%h", proc.mips.dp.gpr.registers[0], 32'h0);
    end
    step(1);
    total++;
    if (proc.mips.dp.gpr.registers[7] !== 32'd3) begin
      bad++; $display("FAIL r7_set got=%h exp=%h", proc.mips.dp.gpr.registers[7], 32'd3);
    end
    step(1);
    total++;
    if (proc.mips.dp.gpr.registers[7] !== 32'h0) begin
      bad++; $display("FAIL r7_clear got=%h exp=%h", proc.mips.dp.gpr.registers[7], 32'h0);
    end
    step(1);
    total++;
    if (proc.pc !== 32'h100 || proc.instr !== 32'h2000_0009) begin
      bad++; $display("FAIL rom_wrap got=%h/%h exp=%h/%h", proc.pc, proc.instr, 32'h100, 32'h2000_0009);
    end
  endtask

  task automatic test_async_reset();
    clear_prog();
    prog[0] = 32'hAC00_0008;  // sw   $0,8($0)
    prog[1] = 32'h2003_0007;  // addi $3,$0,7
    prog[2] = 32'h2002_0005;  // addi $2,$0,5
    prog[3] = 32'hAC03_0008;  // sw   $3,8($0)
    prog[4] = 32'h0800_0000;  // j 0
    start_prog();
    step(3);
    total++;
    if (proc.pc !== 32'hC || proc.mips.dp.gpr.registers[3] !== 32'd7) begin
      bad++;
      $display("FAIL ar_pre got=%h/%h exp=%h/%h", proc.pc, proc.mips.dp.gpr.registers[3], 32'hC, 32'd7);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (proc.pc !== 32'h0) begin
      bad++; $display("FAIL ar_pc got=%h exp=%h", proc.pc, 32'h0);
    end
    total++;
    if (nonzero_regs() !== 0) begin
      bad++; $display("FAIL ar_regs nonzero=%0d exp=0", nonzero_regs());
    end
    total++;
    if (proc.datawrite !== 1'b0 || proc.instr !== 32'hAC00_0008) begin
      bad++;
      $display("FAIL ar_dw_instr got=%b/%h exp=0/%h", proc.datawrite, proc.instr, 32'hAC00_0008);
    end
    step(1);
    total++;
    if (proc.dmem.DATARAM[2] !== 32'h0 || proc.pc !== 32'h0) begin
      bad++; $display("FAIL ar_hold got=%h/%h exp=0/0", proc.dmem.DATARAM[2], proc.pc);
    end
    @(negedge clk);
    reset = 1'b1;
    step(3);
    total++;
    if (proc.pc !== 32'hC || proc.mips.dp.gpr.registers[2] !== 32'd5) begin
      bad++;
      $display("FAIL ar_restart got=%h/%h exp=%h/%h", proc.pc, proc.mips.dp.gpr.registers[2], 32'hC, 32'd5);
    end
    step(2);
    total++;
    if (proc.dmem.DATARAM[2] !== 32'd7 || proc.pc !== 32'h0) begin
      bad++;
      $display("FAIL ar_store got=%h/%h exp=%h/%h", proc.dmem.DATARAM[2], proc.pc, 32'd7, 32'h0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    a = 32'h0;
    b = 32'h0;
    alucontrol = 3'b000;
    test_reset();
    test_alu();
    test_arith();
    test_memory();
    test_branch_jump();
    test_logic_ops();
    test_reg_zero();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
